// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit framer state encoding.
package eth_pkg;
   localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
   localparam logic [7:0]  ETH_SFD        = 8'hD5;
   localparam logic [31:0] CRC32_POLY     = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
   localparam logic [1:0]  RGMII_CTL_IDLE = 2'b00;
   localparam logic [1:0]  RGMII_CTL_DATA = 2'b11;
   localparam logic [1:0]  RGMII_CTL_ERR  = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG,
      ST_DROP
   } tx_state_t;
endpackage

// File: rtl/crc32_d8.sv
// One byte step of the reflected Ethernet CRC-32, LSB first; shared with the RX checker.
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);
   always_comb begin
      crc_out = crc_in ^ {24'h000000, d};
      for (int i = 0; i < 8; i++)
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
   end
endmodule

// File: rtl/rgmii_tx_framer.sv
// Ethernet TX framer: wraps a byte stream with preamble/SFD, pad, FCS and IFG for the RGMII DDR mux.
//
// state    | meaning
// IDLE     | wire idle, waiting for s_valid (first byte held)
// PREAMBLE | 0x55 on the wire
// SFD      | 0xD5 on the wire, first byte accepted
// DATA     | streaming frame bytes into CRC
// PAD      | zero bytes up to MIN_LEN
// FCS      | ~CRC, LSB byte first
// IFG      | idle gap before returning to IDLE
// DROP     | after underrun, discard until s_last while the gap runs
module rgmii_tx_framer
   import eth_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_LEN      = 60,
   parameter int IFG_LEN      = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  tx_data,
   output logic [1:0]  tx_ctl,
   output logic        busy,
   output logic [15:0] frame_count,
   output logic [15:0] underrun_count
);
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
   localparam logic [15:0] MIN_CNT  = 16'(MIN_LEN);

   tx_state_t   state;
   logic [15:0] timer;
   logic [15:0] byte_cnt;
   logic [15:0] cnt_base;
   logic [15:0] cnt_inc;
   logic [31:0] crc;
   logic [31:0] crc_base;
   logic [31:0] crc_next;
   logic [31:0] fcs;
   logic [7:0]  crc_d;
   logic [7:0]  fcs_byte;
   logic        accept;

   // The first payload byte is taken during SFD, so it starts from a fresh CRC and count.
   assign crc_base = (state == ST_SFD) ? CRC32_INIT : crc;
   assign cnt_base = (state == ST_SFD) ? 16'd0 : byte_cnt;
   assign cnt_inc  = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
   assign crc_d    = (state == ST_PAD) ? 8'h00 : s_data;
   assign accept   = s_valid && s_ready;
   assign fcs      = ~crc;

   always_comb begin
      case (timer[1:0])
         2'd3:    fcs_byte = fcs[7:0];
         2'd2:    fcs_byte = fcs[15:8];
         2'd1:    fcs_byte = fcs[23:16];
         default: fcs_byte = fcs[31:24];
      endcase
   end

   crc32_d8 u_crc (
      .crc_in (crc_base),
      .d      (crc_d),
      .crc_out(crc_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         timer          <= 16'd0;
         byte_cnt       <= 16'd0;
         crc            <= CRC32_INIT;
         tx_data        <= 8'h00;
         tx_ctl         <= RGMII_CTL_IDLE;
         s_ready        <= 1'b0;
         busy           <= 1'b0;
         frame_count    <= 16'd0;
         underrun_count <= 16'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx_data <= 8'h00;
               tx_ctl  <= RGMII_CTL_IDLE;
               if (s_valid) begin
                  state   <= ST_PREAMBLE;
                  timer   <= PRE_LAST;
                  busy    <= 1'b1;
                  tx_data <= ETH_PREAMBLE;
                  tx_ctl  <= RGMII_CTL_DATA;
               end
            end
            ST_PREAMBLE: begin
               tx_ctl <= RGMII_CTL_DATA;
               if (timer == 16'd0) begin
                  state   <= ST_SFD;
                  tx_data <= ETH_SFD;
                  s_ready <= 1'b1;
               end else begin
                  timer   <= timer - 16'd1;
                  tx_data <= ETH_PREAMBLE;
               end
            end
            ST_SFD, ST_DATA: begin
               if (accept) begin
                  tx_data  <= s_data;
                  tx_ctl   <= RGMII_CTL_DATA;
                  crc      <= crc_next;
                  byte_cnt <= cnt_inc;
                  if (s_last) begin
                     s_ready <= 1'b0;
                     timer   <= 16'd3;
                     state   <= (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                  end else begin
                     state <= ST_DATA;
                  end
               end else begin
                  tx_data        <= 8'h00;
                  tx_ctl         <= RGMII_CTL_ERR;
                  underrun_count <= underrun_count + 16'd1;
                  timer          <= IFG_LAST;
                  state          <= ST_DROP;
               end
            end
            ST_PAD: begin
               tx_data  <= 8'h00;
               tx_ctl   <= RGMII_CTL_DATA;
               crc      <= crc_next;
               byte_cnt <= cnt_inc;
               if (cnt_inc >= MIN_CNT) begin
                  state <= ST_FCS;
                  timer <= 16'd3;
               end
            end
            ST_FCS: begin
               tx_data <= fcs_byte;
               tx_ctl  <= RGMII_CTL_DATA;
               if (timer == 16'd0) begin
                  frame_count <= frame_count + 16'd1;
                  timer       <= IFG_LAST;
                  state       <= ST_IFG;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            ST_IFG: begin
               tx_data <= 8'h00;
               tx_ctl  <= RGMII_CTL_IDLE;
               if (timer == 16'd0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  timer <= timer - 16'd1;
               end
            end
            ST_DROP: begin
               tx_data <= 8'h00;
               tx_ctl  <= RGMII_CTL_IDLE;
               if (timer != 16'd0)
                  timer <= timer - 16'd1;
               // The gap keeps running while bytes drain; leave only once both are done.
               if (accept && s_last) begin
                  s_ready <= 1'b0;
                  if (timer == 16'd0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_IFG;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
